// File: rtl/bcd_conv_sequencer_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   DIGIT_W    width of one packed BCD digit
//   state_t    converter FSM states (IDLE -> SHIFT -> DONE -> IDLE)
//   clog2()    bit-counter width helper (never returns less than 1)
//   max_bcd()  largest value representable in a given number of BCD digits
//   MAX_BCD    max_bcd() for the default eight-digit readout
package bcd_conv_sequencer_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic logic [63:0] max_bcd(input int unsigned digits);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < digits; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_BCD = max_bcd(8);

endpackage

// File: rtl/bcd_conv_sequencer_digit_cell.sv
// One BCD digit of the double-dabble chain.
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         clear the digit to 0 (new conversion)
//   shift_en    adjust (+3 when >= 5) and then shift left by one
//   sat         force the digit to 9 (saturated display value)
//   shift_in    bit shifted into the digit LSB
//   shift_out   adjusted MSB leaving towards the next digit
//   digit       current digit value
module bcd_digit_cell
  import bcd_conv_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               sat,
  input  logic               shift_in,
  output logic               shift_out,
  output logic [DIGIT_W-1:0] digit
);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] adj;

  // The +3 adjust keeps every digit <= 12, so the 4-bit add cannot wrap.
  always_comb begin
    adj = digit_q;
    if (digit_q >= DIGIT_W'(5)) adj = digit_q + DIGIT_W'(3);
  end

  assign shift_out = adj[DIGIT_W-1];
  assign digit     = digit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else if (clr) begin
      digit_q <= '0;
    end else if (sat) begin
      digit_q <= DIGIT_W'(9);
    end else if (shift_en) begin
      digit_q <= {adj[DIGIT_W-2:0], shift_in};
    end
  end

endmodule

// File: rtl/bcd_conv_sequencer.sv
// Sequential binary-to-BCD converter for the frequency counter readout.
// Converts one bit per clock (double dabble); result is ready BIN_W edges
// after the input handshake.
//   clk, rst_n          clock, asynchronous active-low reset
//   bin/in_valid/in_ready   input count handshake (in_ready registered)
//   abort               synchronous discard of the conversion in flight
//   bcd/out_valid/out_ready output digits handshake; bcd[3:0] = ones
//   ovf                 input exceeded 10^DIGITS-1 (tied 0 unless enabled)
//   busy                high while in SHIFT or DONE
// Build option: define BCD_OVF_SAT_EN to register the overflow flag and
// saturate the displayed value to all 9s on overflow.
module bcd_conv_sequencer
  import bcd_conv_sequencer_pkg::*;
#(
  parameter int unsigned BIN_W  = 27,
  parameter int unsigned DIGITS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BIN_W-1:0]            bin,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        abort,
  output logic [DIGIT_W*DIGITS-1:0]   bcd,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        ovf,
  output logic                        busy
);

  localparam int unsigned        CNT_W    = clog2(BIN_W);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BIN_W - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               accept;
  logic               clr;
  logic               shift_en;
  logic               last;
  logic               sat;

  // abort overrides every handshake and freezes the digit registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    accept   = 1'b0;
    clr      = 1'b0;
    shift_en = 1'b0;
    last     = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            accept  = 1'b1;
            clr     = 1'b1;
            sr_d    = bin;
            cnt_d   = CNT_LAST;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shift_en = 1'b1;
          sr_d     = sr_q << 1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            last    = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

`ifdef BCD_OVF_SAT_EN
  localparam logic [63:0] MAX_VAL = max_bcd(DIGITS);
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= (64'(bin) > MAX_VAL);
    end
  end

  // Saturation replaces the final shift so DONE shows all 9s.
  assign sat = last & ovf_q;
  assign ovf = ovf_q;
`else
  assign sat = 1'b0;
  assign ovf = 1'b0;
`endif

  logic [DIGITS-1:0] chain;
  logic              top_carry_unused;

  assign chain[0] = sr_q[BIN_W-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    if (g == DIGITS - 1) begin : g_top
      bcd_digit_cell u_cell (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .shift_en  (shift_en),
        .sat       (sat),
        .shift_in  (chain[g]),
        .shift_out (top_carry_unused),
        .digit     (bcd[g*DIGIT_W +: DIGIT_W])
      );
    end else begin : g_mid
      bcd_digit_cell u_cell (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .shift_en  (shift_en),
        .sat       (sat),
        .shift_in  (chain[g]),
        .shift_out (chain[g+1]),
        .digit     (bcd[g*DIGIT_W +: DIGIT_W])
      );
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);

endmodule
